// File: rtl/conv2d_stream_filter.sv
// conv2d_stream_filter: streaming KxK 2-D convolution over a raster-order
// grayscale image with zero-padded borders, runtime normalisation shift,
// optional absolute value, saturation to [0, 2^W-1], end-of-frame flush
// and a frame_done pulse.  One output is produced per input pixel.
// Optional feature macro: CONV_SAT_STATS_EN adds the sat_count port and a
// per-frame count of clamped outputs.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; valid/data are held by the producer until that edge, and
// ready may depend combinationally on the consumer's own output register.
module conv2d_stream_filter #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int K          = 3,
    parameter int W          = 8,
    parameter int KW         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic [W-1:0]      x_data,
    output logic              y_valid,
    input  logic              y_ready,
    output logic [W-1:0]      y_data,
    input  logic [K*K*KW-1:0] kernel,
    input  logic [3:0]        norm_shift,
    input  logic              abs_mode,
`ifdef CONV_SAT_STATS_EN
    output logic              frame_done,
    output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0] sat_count
`else
    output logic              frame_done
`endif
);

    localparam int R    = (K - 1) / 2;
    localparam int ACCW = W + KW + 1 + $clog2(K * K);
    localparam int CW   = $clog2(IMG_WIDTH);
    localparam int IRW  = $clog2(IMG_HEIGHT + K);
    localparam int ORW  = $clog2(IMG_HEIGHT + 1);
    localparam int OFF  = R * IMG_WIDTH + R;
    localparam int FW   = $clog2(OFF + 1);
    localparam logic signed [ACCW-1:0] MAXV = signed'({{(ACCW-W){1'b0}}, {W{1'b1}}});

    localparam logic [0:0] ST_STREAM = 1'b0;
    localparam logic [0:0] ST_FLUSH  = 1'b1;

    logic [0:0]        state;
    logic [CW-1:0]     in_c;
    logic [IRW-1:0]    in_r;
    logic [CW-1:0]     out_c;
    logic [ORW-1:0]    out_r;
    logic [FW-1:0]     flush_left;
    logic [K*K*KW-1:0] kern_q;
    logic [3:0]        shift_q;
    logic              abs_q;
    logic [W-1:0]      lb   [0:K-2][0:IMG_WIDTH-1];
    logic [W-1:0]      win  [0:K-1][0:K-1];
    logic [W-1:0]      nwin [0:K-1][0:K-1];
    logic [W-1:0]      pix_in;
    logic [W-1:0]      result;
    logic signed [ACCW-1:0] shifted;
    logic              out_free, take, step, emit, primed, last_in, first_in;

    assign out_free   = !y_valid || y_ready;
    assign x_ready    = rst_n && (state == ST_STREAM) && out_free;
    assign take       = x_valid && x_ready;
    // Flush steps feed virtual zero pixels through the same datapath.
    assign step       = take || (rst_n && (state == ST_FLUSH) && (flush_left != '0) && out_free);
    assign last_in    = (in_r == IRW'(IMG_HEIGHT - 1)) && (in_c == CW'(IMG_WIDTH - 1));
    assign first_in   = (in_r == '0) && (in_c == '0);
    // Output exists once the input index has passed R rows plus R columns.
    assign primed     = (state == ST_FLUSH) || (in_r > IRW'(R)) ||
                        ((in_r == IRW'(R)) && (in_c >= CW'(R)));
    assign emit       = step && primed;
    assign frame_done = rst_n && (state == ST_FLUSH) && (flush_left == '0) && y_valid && y_ready;
    assign pix_in     = (state == ST_STREAM) ? x_data : '0;

    // Next window: shift left one column and bring in the new column from the line buffers.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
                nwin[i][j] = win[i][j+1];
            end
        end
        for (int i = 0; i < K - 1; i++) begin
            nwin[i][K-1] = lb[K-2-i][in_c];
        end
        nwin[K-1][K-1] = pix_in;
    end

    // Multiply-accumulate with padding mask, then shift, abs and clamp.
    always_comb begin : calc
        logic signed [ACCW-1:0] acc;
        logic signed [W:0]      pxs;
        logic signed [KW-1:0]   cf;
        logic signed [W+KW:0]   prod;
        logic [W-1:0]           px;
        int rr;
        int cc;
        acc     = '0;
        pxs     = '0;
        cf      = '0;
        prod    = '0;
        px      = '0;
        rr      = 0;
        cc      = 0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                rr = int'(out_r) + i - R;
                cc = int'(out_c) + j - R;
                if (rr >= 0 && rr < IMG_HEIGHT && cc >= 0 && cc < IMG_WIDTH)
                    px = nwin[i][j];
                else
                    px = '0;
                pxs  = signed'({1'b0, px});
                cf   = signed'(kern_q[(i*K+j)*KW +: KW]);
                prod = pxs * cf;
                acc  = acc + ACCW'(prod);
            end
        end
        shifted = acc >>> shift_q;
        if (abs_q && shifted[ACCW-1])
            shifted = -shifted;
        if (shifted[ACCW-1])
            result = '0;
        else if (shifted > MAXV)
            result = '1;
        else
            result = shifted[W-1:0];
    end

    // Line buffers and window advance on every real or virtual pixel.
    always_ff @(posedge clk) begin
        if (step) begin
            lb[0][in_c] <= pix_in;
            for (int k = 1; k < K - 1; k++) begin
                lb[k][in_c] <= lb[k-1][in_c];
            end
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win[i][j] <= nwin[i][j];
                end
            end
        end
    end

    // Coefficients and modes are frozen at the first pixel of each frame.
    always_ff @(posedge clk) begin
        if (take && first_in) begin
            kern_q  <= kernel;
            shift_q <= norm_shift;
            abs_q   <= abs_mode;
        end
    end

    // Control FSM: position counters, output register, flush sequencing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_STREAM;
            in_c       <= '0;
            in_r       <= '0;
            out_c      <= '0;
            out_r      <= '0;
            flush_left <= '0;
            y_valid    <= 1'b0;
            y_data     <= '0;
        end else begin
            if (step) begin
                if (in_c == CW'(IMG_WIDTH - 1)) begin
                    in_c <= '0;
                    in_r <= in_r + IRW'(1);
                end else begin
                    in_c <= in_c + CW'(1);
                end
            end
            if (emit) begin
                y_data  <= result;
                y_valid <= 1'b1;
                if (out_c == CW'(IMG_WIDTH - 1)) begin
                    out_c <= '0;
                    out_r <= out_r + ORW'(1);
                end else begin
                    out_c <= out_c + CW'(1);
                end
            end else if (y_ready) begin
                y_valid <= 1'b0;
            end
            if (take && last_in) begin
                state      <= ST_FLUSH;
                flush_left <= FW'(OFF);
            end else if (step && (state == ST_FLUSH)) begin
                flush_left <= flush_left - FW'(1);
            end
            if (frame_done) begin
                state <= ST_STREAM;
                in_c  <= '0;
                in_r  <= '0;
                out_c <= '0;
                out_r <= '0;
            end
        end
    end

`ifdef CONV_SAT_STATS_EN
    localparam int SCW = $clog2(IMG_WIDTH * IMG_HEIGHT + 1);
    logic [SCW-1:0] sat_cnt;
    logic           sat;
    assign sat = shifted[ACCW-1] || (shifted > MAXV);

    // Per-frame count of clamped outputs, published when the frame completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_cnt   <= '0;
            sat_count <= '0;
        end else begin
            if (take && first_in)
                sat_cnt <= '0;
            else if (emit && sat)
                sat_cnt <= sat_cnt + SCW'(1);
            if (frame_done)
                sat_count <= sat_cnt;
        end
    end
`endif

endmodule

// File: doc/conv2d_stream_filter.md
Name: conv2d_stream_filter

Overview:
- Next-generation streaming 2-D convolution filter for the pattern-recognition path.
- Generalises the fixed 3x3 grayscale filter to an odd kernel size K and configurable pixel and coefficient widths.
- Adds zero-padded borders, runtime normalisation shift, absolute-value mode, saturation, an end-of-frame flush and a frame-done pulse.
- Sits between the grayscale pixel source and downstream detectors. Uses valid/ready streams in raster order and emits exactly one output per input pixel.

Parameters:
- IMG_WIDTH, 640, pixels per row (≥ K)
- IMG_HEIGHT, 480, rows per frame (≥ K)
- K, 3, kernel side length; odd, 3..7; R = (K-1)/2
- W, 8, unsigned pixel width in and out
- KW, 8, signed two's-complement kernel coefficient width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- x_valid  in  1  input pixel valid
- x_ready  out  1  block accepts input
- x_data  in  W  input pixel, unsigned
- y_valid  out  1  output pixel valid
- y_ready  in  1  downstream accepts output
- y_data  out  W  filtered pixel, unsigned
- kernel  in  K*K*KW  coefficients; tap (i,j) at bits [(i*K+j)*KW +: KW], i = row, j = column, (0,0) = top-left
- norm_shift  in  4  arithmetic right shift applied to the sum
- abs_mode  in  1  1 = take the absolute value after the shift
- frame_done  out  1  one-cycle pulse when the frame's last output is accepted

Behaviour:
- Reset: x_ready=0 for the reset cycle; y_valid=0, y_data=0, frame_done=0; row/col counters=0; state=STREAM. Line-buffer contents are not reset; correctness must never depend on them.
- Coefficient and mode capture: kernel, norm_shift and abs_mode are registered on the handshake of input pixel 0 of each frame. They are held for the whole frame, including flush.
- Storage: K-1 line buffers of IMG_WIDTH x W, plus a K x K window register.
- Output definition: output (r,c) = Σ kernel[i][j] * P(r+i-R, c+j-R). P = 0 for any position outside the image (zero padding, including column wrap across rows).
- Arithmetic:
  - Pixels are zero-extended to signed W+1 bits.
  - Accumulator width is W+KW+1+clog2(K*K); no overflow is possible.
  - The sum is shifted right arithmetically by norm_shift.
  - If abs_mode=1, the absolute value is taken after the shift.
  - The result is then clamped to [0, 2^W-1].
- State STREAM:
  - x_ready = !y_valid || y_ready.
  - Accepting linear input index n emits output index n - (R*IMG_WIDTH + R) if that index is ≥ 0.
  - That output is registered and y_valid is asserted on the cycle after the handshake (latency 1).
- State FLUSH:
  - Entered after the handshake of the frame's last input pixel.
  - x_ready=0 throughout.
  - The block emits the remaining R*IMG_WIDTH + R outputs, treating all not-yet-received taps as 0, one per cycle when downstream is ready.
  - Returns to STREAM once the last output has been accepted.
  - frame_done pulses on that same accept cycle.
- Backpressure: y_valid with y_ready=0 holds y_data stable, and no new input is taken. No output is dropped or duplicated.
- Frame boundary: counters wrap to (0,0) after flush. The next frame starts clean, with no leakage from the previous frame because of the padding mask.
- Reset mid-frame: all partial state is discarded. The first pixel after reset is treated as pixel (0,0) of a new frame.
- x_valid while x_ready=0 is ignored; the source holds its data per the valid/ready protocol.

Optional Feature:
- Macro: CONV_SAT_STATS_EN
- Defined:
  - Adds output port sat_count (clog2(IMG_WIDTH*IMG_HEIGHT+1) bits).
  - Counts the outputs clamped at 0 or at 2^W-1 during the current frame, where the pre-clamp value was <0 or >2^W-1.
  - The count is latched into sat_count on the frame_done cycle.
  - The internal counter clears at the start of each frame.
  - sat_count resets to 0.
- Undefined: no port and no counter logic; behaviour is otherwise identical.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=6, K=3, W=8, KW=8 unless stated):
- Identity kernel (centre=1), random image, y_ready=1 -> output equals input exactly; 48 outputs; frame_done pulses once on the 48th accept.
- Box kernel all 1s, shift 0, constant 10 -> interior 90, edges 60, corners 40. Same image with shift 3 -> interior 11, edges 7, corners 5.
- Sharpen [0,-1,0;-1,5,-1;0,-1,0], constant 100 -> interior 100, edges 200, corners 255 (clamped from 300). With CONV_SAT_STATS_EN: sat_count=4.
- Edge kernel (-1s, centre 8), single 255 impulse at (2,3), rest 0:
  - abs_mode=0 -> (2,3)=255 (clamped from 2040), its 8 neighbours 0, all else 0.
  - abs_mode=1 -> (2,3)=255, neighbours 255.
- Random y_ready (~50% duty) and random x_valid gaps -> output stream bit-identical to the y_ready=1 run; y_data stable while stalled; x_ready=0 throughout flush.
- Reset asserted after 20 inputs, then a full 48-pixel frame -> exactly 48 outputs matching a clean-run reference; no output is produced from the aborted frame after reset.
